// File: rtl/norm_round_unit_pkg.sv
// Shared types and constants for the FP multiplier normalize/round datapath.
// Latency: n/a (types, constants and a combinational packing helper only).
// Backpressure: n/a.
package fp_mul_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int PROD_W  = 48;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  // Working exponent is signed and two bits wider than the IEEE field, so
  // overflow and underflow stay visible until the final range check.
  localparam int SEXP_W  = 10;

  localparam logic signed [SEXP_W-1:0] SEXP_MAX  = SEXP_W'(EXP_MAX);
  localparam logic signed [SEXP_W-1:0] SEXP_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM   = 3'd1,
    ROUND  = 3'd2,
    RENORM = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic        over;
    logic        under;
  } res_t;

  // Final range check and IEEE single packing of sign/exponent/fraction.
  function automatic res_t pack_result(input logic                     sign,
                                       input logic signed [SEXP_W-1:0] exp,
                                       input logic [FRAC_W-1:0]        frac);
    res_t r;
    r.word  = {sign, exp[EXP_W-1:0], frac};
    r.over  = 1'b0;
    r.under = 1'b0;
    if (exp >= SEXP_MAX) begin
      r.word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r.over = 1'b1;
    end else if (exp <= SEXP_ZERO) begin
      r.word  = {sign, 31'b0};
      r.under = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/norm_round_unit_if.sv
// Request/result bundle between the multiplier controller and norm_round_unit.
// Latency: n/a (wires only).
// Backpressure: StartR is a level request; DoneR holds until StartR is dropped.
// Ports: StartR/Sign_i/Exp_i/Mant_i from controller; Result_o/DoneR/Over2/Under_o back.
interface norm_round_unit_if;
  import fp_mul_pkg::*;

  logic                     StartR;
  logic                     Sign_i;
  logic [SEXP_W-1:0]        Exp_i;
  logic [PROD_W-1:0]        Mant_i;
  logic [31:0]              Result_o;
  logic                     DoneR;
  logic                     Over2;
  logic                     Under_o;

  // Controller side.
  modport master (
    output StartR, Sign_i, Exp_i, Mant_i,
    input  Result_o, DoneR, Over2, Under_o
  );

  // Normalize/round unit side.
  modport slave (
    input  StartR, Sign_i, Exp_i, Mant_i,
    output Result_o, DoneR, Over2, Under_o
  );

endinterface

// File: rtl/norm_round_unit_rne_round.sv
// Round-to-nearest-even decision and 24-bit significand increment.
// Latency: combinational.
// Backpressure: none.
// Ports: mant_i (product bits 45:0, hidden bit implied at 46), sticky_i,
//        frac_o (rounded fraction), carry_o (increment overflowed 24 bits).
module rne_round
  import fp_mul_pkg::*;
(
  input  logic [PROD_W-3:0] mant_i,
  input  logic              sticky_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o
);

  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              inc;
  logic [FRAC_W+1:0] sum;

  assign lsb    = mant_i[PROD_W-FRAC_W-2];
  assign guard  = mant_i[PROD_W-FRAC_W-3];
  assign sticky = (|mant_i[PROD_W-FRAC_W-4:0]) | sticky_i;
  // Ties (guard set, nothing below) round up only when the kept LSB is odd.
  assign inc    = guard & (sticky | lsb);

  assign sum    = {2'b01, mant_i[PROD_W-3:PROD_W-FRAC_W-2]} + {{(FRAC_W+1){1'b0}}, inc};

  // On overflow the hidden position drops to 0 and bit 24 becomes set.
  assign carry_o = sum[FRAC_W+1] & ~sum[FRAC_W];
  assign frac_o  = sum[FRAC_W-1:0];

endmodule

// File: rtl/norm_round_unit.sv
// Normalizes a 48-bit significand product, rounds RNE, packs IEEE single.
// Latency: DoneR 3 edges after StartR sampled, +1 per left shift, +1 on renormalize.
// Backpressure: result and DoneR held in DONE until StartR is dropped.
// Ports: CLK, Reset (async, active high), nru (slave side of norm_round_unit_if).
module norm_round_unit
  import fp_mul_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  norm_round_unit_if.slave nru
);

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [SEXP_W-1:0] exp_q, exp_d;
  logic [PROD_W-1:0]        mant_q, mant_d;
  logic                     sticky_q, sticky_d;
  res_t                     res_q, res_d;
  logic                     done_q, done_d;

  logic [FRAC_W-1:0]        rnd_frac;
  logic                     rnd_carry;

  rne_round u_rne_round (
    .mant_i   (mant_q[PROD_W-3:0]),
    .sticky_i (sticky_q),
    .frac_o   (rnd_frac),
    .carry_o  (rnd_carry)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (nru.StartR) begin
          sign_d   = nru.Sign_i;
          exp_d    = $signed(nru.Exp_i);
          mant_d   = nru.Mant_i;
          sticky_d = 1'b0;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          res_d   = '{word: {sign_q, 31'b0}, over: 1'b0, under: 1'b0};
          state_d = DONE;
        end else if (mant_q[PROD_W-1]) begin
          // Product in [2,4): one right shift, the dropped bit feeds sticky.
          mant_d   = {1'b0, mant_q[PROD_W-1:1]};
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + SEXP_W'(1);
          state_d  = ROUND;
        end else if (mant_q[PROD_W-2]) begin
          state_d = ROUND;
        end else begin
          // Leading one below the hidden position: walk it up one bit per cycle.
          mant_d = {mant_q[PROD_W-2:0], 1'b0};
          exp_d  = exp_q - SEXP_W'(1);
        end
      end

      ROUND: begin
        if (rnd_carry) begin
          // 1.111..1 rounded up to 10.000..0: fraction becomes zero, exponent bumps.
          exp_d   = exp_q + SEXP_W'(1);
          state_d = RENORM;
        end else begin
          res_d   = pack_result(sign_q, exp_q, rnd_frac);
          state_d = DONE;
        end
      end

      RENORM: begin
        res_d   = pack_result(sign_q, exp_q, {FRAC_W{1'b0}});
        state_d = DONE;
      end

      DONE: begin
        done_d = 1'b1;
        if (!nru.StartR) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign nru.Result_o = res_q.word;
  assign nru.Over2    = res_q.over;
  assign nru.Under_o  = res_q.under;
  assign nru.DoneR    = done_q;

endmodule

// File: tb/tb_norm_round_unit.sv
module tb_norm_round_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  norm_round_unit_if bus ();

  norm_round_unit u_dut (
    .CLK   (clk),
    .Reset (reset),
    .nru   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Apply one operation; lat counts rising edges after the edge that samples StartR.
  task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input bit hold, input int lat,
                        input logic [31:0] res, input logic ov, input logic un);
    int got_lat;
    int drop;
    @(negedge clk);
    bus.Sign_i = s;
    bus.Exp_i  = e;
    bus.Mant_i = m;
    bus.StartR = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: the unit must work from its captured copy.
    bus.Sign_i = ~s;
    bus.Exp_i  = e ^ 10'h155;
    bus.Mant_i = ~m;
    if (!hold) bus.StartR = 1'b0;
    got_lat = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (bus.DoneR === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    chk({tag, " latency"}, got_lat, lat);
    chk({tag, " result"}, bus.Result_o, res);
    chk({tag, " over"}, {31'b0, bus.Over2}, {31'b0, ov});
    chk({tag, " under"}, {31'b0, bus.Under_o}, {31'b0, un});
    if (hold) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      chk({tag, " done held"}, {31'b0, bus.DoneR}, 32'd1);
      chk({tag, " result held"}, bus.Result_o, res);
      @(negedge clk);
      bus.StartR = 1'b0;
    end
    drop = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.DoneR === 1'b0) begin
        drop = 1;
        break;
      end
    end
    chk({tag, " done release"}, drop, 1);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b1;
    bus.StartR = 1'b0;
    bus.Sign_i = 1'b0;
    bus.Exp_i  = '0;
    bus.Mant_i = '0;
    #1;
    chk("reset result", bus.Result_o, 32'h0);
    chk("reset done", {31'b0, bus.DoneR}, 32'd0);
    chk("reset over", {31'b0, bus.Over2}, 32'd0);
    chk("reset under", {31'b0, bus.Under_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("mul15",    1'b0, 10'd127, 48'h900000000000, 1'b1, 3, 32'h40100000, 1'b0, 1'b0);
    run_op("rcarry",   1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 4, 32'h40000000, 1'b0, 1'b0);
    run_op("tieeven",  1'b0, 10'd127, 48'h400000400000, 1'b0, 3, 32'h3F800000, 1'b0, 1'b0);
    run_op("tieodd",   1'b0, 10'd127, 48'h400000C00000, 1'b0, 3, 32'h3F800002, 1'b0, 1'b0);
    run_op("sticky",   1'b0, 10'd127, 48'h800000800001, 1'b0, 3, 32'h40000001, 1'b0, 1'b0);
    run_op("nosticky", 1'b0, 10'd127, 48'h800000800000, 1'b0, 3, 32'h40000000, 1'b0, 1'b0);
    run_op("ovf",      1'b0, 10'd254, 48'h800000000000, 1'b0, 3, 32'h7F800000, 1'b1, 1'b0);
    run_op("ovfrenorm",1'b1, 10'd254, 48'h7FFFFFC00000, 1'b0, 4, 32'hFF800000, 1'b1, 1'b0);
    run_op("ovfbig",   1'b0, 10'd300, 48'h400000000000, 1'b0, 3, 32'h7F800000, 1'b1, 1'b0);
    run_op("lshift",   1'b0, 10'd130, 48'h100000000000, 1'b0, 5, 32'h40000000, 1'b0, 1'b0);
    run_op("zero",     1'b1, 10'd127, 48'h000000000000, 1'b0, 2, 32'h80000000, 1'b0, 1'b0);
    run_op("unf",      1'b1, 10'd0,   48'h400000000000, 1'b0, 3, 32'h80000000, 1'b0, 1'b1);
    run_op("unfneg",   1'b0, 10'h3FB, 48'h400000000000, 1'b0, 3, 32'h00000000, 1'b0, 1'b1);
    run_op("lshift46", 1'b0, 10'd127, 48'h000000000001, 1'b0, 49, 32'h28800000, 1'b0, 1'b0);

    // Reset while the unit is still left-shifting in NORM.
    @(negedge clk);
    bus.Sign_i = 1'b0;
    bus.Exp_i  = 10'd130;
    bus.Mant_i = 48'h100000000000;
    bus.StartR = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.StartR = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset result", bus.Result_o, 32'h0);
    chk("midreset done", {31'b0, bus.DoneR}, 32'd0);
    chk("midreset over", {31'b0, bus.Over2}, 32'd0);
    chk("midreset under", {31'b0, bus.Under_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midreset discarded", {31'b0, bus.DoneR}, 32'd0);

    run_op("mul15 after reset", 1'b0, 10'd127, 48'h900000000000, 1'b0, 3, 32'h40100000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
